inv_mxcol_seq: RTL and testbench



---
 rtl/inv_mxcol_seq.sv | 115 +++++++++++
 tb/tb_inv_mxcol_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mxcol_seq.sv
// rtl/inv_mxcol_seq.sv - sequential S-AES inverse MixColumns, matrix [[9,2],[2,9]] over GF(2^4)
`timescale 1ns/1ps
module inv_mxcol_seq #(
  parameter bit COL_SERIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] state_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] state_out,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, COL0, COL1, COMP, DONE} state_t;

  state_t      state_q;
  logic [15:0] st_q;
  logic [15:0] res_q;
  logic [15:0] res_d;
  logic [15:0] state_out_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  function automatic logic [3:0] xtime(input logic [3:0] a);
    xtime = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul2(input logic [3:0] a);
    mul2 = xtime(a);
  endfunction

  function automatic logic [3:0] mul9(input logic [3:0] a);
    mul9 = xtime(xtime(xtime(a))) ^ a;
  endfunction

  // Nibble packing {s00,s01,s10,s11}: column 0 = [15:12]/[7:4], column 1 = [11:8]/[3:0].
  logic [3:0] c0_top, c0_bot, c1_top, c1_bot;
  always_comb begin
    c0_top = mul9(st_q[15:12]) ^ mul2(st_q[7:4]);
    c0_bot = mul2(st_q[15:12]) ^ mul9(st_q[7:4]);
    c1_top = mul9(st_q[11:8])  ^ mul2(st_q[3:0]);
    c1_bot = mul2(st_q[11:8])  ^ mul9(st_q[3:0]);
  end

  always_comb begin
    res_d = res_q;
    case (state_q)
      COL0: begin
        res_d[15:12] = c0_top;
        res_d[7:4]   = c0_bot;
      end
      COL1: begin
        res_d[11:8]  = c1_top;
        res_d[3:0]   = c1_bot;
      end
      COMP: res_d = {c0_top, c1_top, c0_bot, c1_bot};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= 16'h0000;
      res_q       <= 16'h0000;
      state_out_q <= 16'h0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      res_q <= res_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q       <= state_in;
            state_q    <= COL_SERIAL ? COL0 : COMP;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        COL0: state_q <= COL1;
        COL1, COMP: begin
          // The output register only ever sees a complete result.
          state_out_q <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = state_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mxcol_seq.sv
// tb/tb_inv_mxcol_seq.sv - directed and model-based checks of inv_mxcol_seq, serial and parallel
`timescale 1ns/1ps
module tb_inv_mxcol_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] state_in  [2];
  logic [15:0] state_out [2];

  int checks = 0;
  int errors = 0;

  inv_mxcol_seq #(.COL_SERIAL(1'b1)) u_ser (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0]),
    .busy(busy[0])
  );

  inv_mxcol_seq #(.COL_SERIAL(1'b0)) u_par (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add GF(2^4) multiply, x^4 = x + 1
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  // Forward MixColumns, matrix [[1,4],[4,1]]
  function automatic logic [15:0] fwd(input logic [15:0] s);
    logic [3:0] a0, b0, a1, b1;
    a0 = s[15:12]; a1 = s[11:8]; b0 = s[7:4]; b1 = s[3:0];
    return {a0 ^ gmul(4'h4, b0), a1 ^ gmul(4'h4, b1),
            gmul(4'h4, a0) ^ b0, gmul(4'h4, a1) ^ b1};
  endfunction

  task automatic send(input int d, input logic [15:0] s, output int edges,
                      output logic [15:0] res, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid[d] = 1'b1;
    state_in[d] = s;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    res = state_out[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++; if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
      checks++; if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
      checks++; if (state_out[d] !== 16'h0000) begin errors++; $display("FAIL reset_state_out[%0d]: got %h want 0000", d, state_out[d]); end
    end
  endtask

  task automatic test_directed;
    logic [15:0] vin  [4];
    logic [15:0] vexp [4];
    int          vdut [4];
    int          vlat [4];
    int edges;
    logic [15:0] res;
    bit ok;
    vin[0] = 16'h1040; vexp[0] = 16'h1000; vdut[0] = 0; vlat[0] = 3;
    vin[1] = 16'hFFFF; vexp[1] = 16'h3333; vdut[1] = 0; vlat[1] = 3;
    vin[2] = 16'h0000; vexp[2] = 16'h0000; vdut[2] = 0; vlat[2] = 3;
    vin[3] = 16'hFFFF; vexp[3] = 16'h3333; vdut[3] = 1; vlat[3] = 2;
    out_ready = 2'b11;
    for (int v = 0; v < 4; v++) begin
      send(vdut[v], vin[v], edges, res, ok);
      checks++; if (!ok) begin errors++; $display("FAIL directed_timeout[%0d]: got no out_valid want out_valid", v); end
      checks++; if (res !== vexp[v]) begin errors++; $display("FAIL directed_result[%0d]: got %h want %h", v, res, vexp[v]); end
      checks++; if (edges != vlat[v]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want %0d", v, edges, vlat[v]); end
      @(negedge clk);
      checks++; if (out_valid[vdut[v]] !== 1'b0) begin errors++; $display("FAIL directed_one_pulse[%0d]: got %b want 0", v, out_valid[vdut[v]]); end
      checks++; if (in_ready[vdut[v]] !== 1'b1) begin errors++; $display("FAIL directed_idle[%0d]: got %b want 1", v, in_ready[vdut[v]]); end
    end
  endtask

  task automatic test_backpressure;
    int edges;
    logic [15:0] res;
    bit ok;
    out_ready[0] = 1'b0;
    send(0, 16'hFFFF, edges, res, ok);
    checks++; if (!ok || res !== 16'h3333) begin errors++; $display("FAIL bp_first: got %h ok=%0d want 3333", res, ok); end
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = c[0];
      state_in[0] = 16'h5555;
      @(negedge clk);
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid[0]); end
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b want 1", c, busy[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready[0]); end
      checks++; if (state_out[0] !== 16'h3333) begin errors++; $display("FAIL bp_state_out[%0d]: got %h want 3333", c, state_out[0]); end
    end
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready[0]); end
    checks++; if (state_out[0] !== 16'h3333) begin errors++; $display("FAIL bp_release_hold: got %h want 3333", state_out[0]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_no_extra[%0d]: busy %b out_valid %b want 0 0", c, busy[0], out_valid[0]); end
    end
  endtask

  task automatic test_reset_mid;
    int edges;
    logic [15:0] res;
    bit ok;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b1;
    state_in[0] = 16'h1040;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy[0]); end
    checks++; if (state_out[0] !== 16'h0000) begin errors++; $display("FAIL rmid_state_out: got %h want 0000", state_out[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 16'h1040, edges, res, ok);
    checks++; if (!ok || res !== 16'h1000 || edges != 3) begin errors++; $display("FAIL rmid_after: got %h lat %0d ok=%0d want 1000 lat 3", res, edges, ok); end
  endtask

  task automatic test_random_sweep;
    int edges;
    logic [15:0] s, res;
    bit ok;
    out_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 1000; n++) begin
        s = 16'($urandom);
        send(d, fwd(s), edges, res, ok);
        checks++; if (!ok || res !== s) begin errors++; $display("FAIL sweep_result[%0d]: got %h want %h", d, res, s); end
        checks++; if (edges != (d == 0 ? 3 : 2)) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", d, edges, (d == 0 ? 3 : 2)); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vs [6];
    logic [15:0] got [$];
    int acc [$];
    int i;
    vs[0] = 16'h1234; vs[1] = 16'hABCD; vs[2] = 16'h0F0F;
    vs[3] = 16'h8001; vs[4] = 16'h7E7E; vs[5] = 16'hC35A;
    i = 0;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid[0]) got.push_back(state_out[0]);
      if (in_ready[0]) begin
        if (i < 6) begin
          in_valid[0] = 1'b1;
          state_in[0] = fwd(vs[i]);
          acc.push_back(c);
          i++;
        end else begin
          in_valid[0] = 1'b0;
        end
      end
    end
    in_valid[0] = 1'b0;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got.size()); end
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      checks++; if (got[j] !== vs[j]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", j, got[j], vs[j]); end
    end
    for (int j = 1; j < acc.size(); j++) begin
      checks++; if (acc[j] - acc[j-1] != 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", j, acc[j] - acc[j-1]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 2'b00;
    out_ready = 2'b00;
    state_in[0] = 16'h0000;
    state_in[1] = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
